// File: rtl/traffic_pkg.sv
// Shared encodings and pick helpers for the intersection request arbiter.
// Roads are numbered N=0, E=1, S=2, W=3 everywhere.
package traffic_pkg;

    localparam logic [1:0] ROAD_N = 2'd0;
    localparam logic [1:0] ROAD_E = 2'd1;
    localparam logic [1:0] ROAD_S = 2'd2;
    localparam logic [1:0] ROAD_W = 2'd3;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_PED  = 2'b01;
    localparam logic [1:0] CMD_EM   = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        SERVE = 2'd2
    } arb_state_e;

    // Lowest set index wins (N before E before S before W).
    function automatic logic [1:0] prio_pick(input logic [3:0] req);
        logic [1:0] sel;
        sel = ROAD_N;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) sel = 2'(i);
        end
        return sel;
    endfunction

    // First set bit at or after ptr, wrapping W back to N.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] sel;
        logic [1:0] idx;
        sel = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) sel = idx;
        end
        return sel;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button debouncer: emits one press pulse after DEBOUNCE_CYC high cycles,
// then stays quiet until the button is released.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Counter parks at DEBOUNCE_CYC so a held button cannot fire twice.
    always_comb begin
        cnt_d = cnt_q;
        if (!raw_i) begin
            cnt_d = '0;
        end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign press_o = raw_i && (cnt_q == CW'(DEBOUNCE_CYC - 1));

endmodule

// File: rtl/traffic_req_arbiter.sv
// Request scheduler: debounced buttons become pending requests, emergencies by
// fixed priority and pedestrians round-robin, offered one at a time to the FSM.
module traffic_req_arbiter
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int PED_HOLDOFF  = 20,
    parameter int EM_TIMEOUT   = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] ped_req,
    input  logic [3:0] em_req,
    input  logic       fsm_ready,
    input  logic       fsm_done,
    output logic       cmd_valid,
    output logic [1:0] cmd_type,
    output logic [1:0] cmd_road,
    output logic [3:0] ped_pending,
    output logic [3:0] em_pending,
    output logic       em_active,
    output logic       err_timeout
);

    localparam int HW = $clog2(PED_HOLDOFF + 1);
    localparam int TW = $clog2(EM_TIMEOUT + 1);

    logic [3:0] ped_press, em_press;

    for (genvar g = 0; g < 4; g++) begin : gen_btn
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ped_db (
            .clk(clk), .reset(reset), .raw_i(ped_req[g]), .press_o(ped_press[g])
        );
        btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_em_db (
            .clk(clk), .reset(reset), .raw_i(em_req[g]), .press_o(em_press[g])
        );
    end

    arb_state_e    state_q, state_d;
    logic [1:0]    type_q, type_d;
    logic [1:0]    road_q, road_d;
    logic [1:0]    rr_q, rr_d;
    logic [3:0]    ped_pend_q, ped_pend_d;
    logic [3:0]    em_pend_q, em_pend_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    logic [3:0]    ped_clr, em_clr;
    logic          hold_load;

    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        road_d    = road_q;
        rr_d      = rr_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        ped_clr   = '0;
        em_clr    = '0;
        hold_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (|em_pend_q) begin
                    type_d  = CMD_EM;
                    road_d  = prio_pick(em_pend_q);
                    state_d = OFFER;
                end else if ((|ped_pend_q) && (hold_q == '0)) begin
                    type_d  = CMD_PED;
                    road_d  = rr_pick(ped_pend_q, rr_q);
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (fsm_ready) begin
                    state_d = SERVE;
                    tmo_d   = '0;
                    if (type_q == CMD_EM) begin
                        em_clr = 4'b0001 << road_q;
                    end else begin
                        ped_clr = 4'b0001 << road_q;
                        rr_d    = road_q + 2'd1;
                    end
                end else if ((type_q == CMD_PED) && (|em_pend_q)) begin
                    // Emergency preempts an unaccepted ped offer; the ped stays pending.
                    type_d = CMD_EM;
                    road_d = prio_pick(em_pend_q);
                end
            end
            SERVE: begin
                if (fsm_done) begin
                    state_d   = IDLE;
                    hold_load = (type_q == CMD_PED);
                end else if (type_q == CMD_EM) begin
                    if (tmo_q == TW'(EM_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ped_pend_d = (ped_pend_q | ped_press) & ~ped_clr;
        em_pend_d  = (em_pend_q | em_press) & ~em_clr;
        if (hold_load)           hold_d = HW'(PED_HOLDOFF);
        else if (hold_q != '0)   hold_d = hold_q - HW'(1);
        else                     hold_d = hold_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            type_q     <= CMD_NONE;
            road_q     <= ROAD_N;
            rr_q       <= ROAD_N;
            ped_pend_q <= '0;
            em_pend_q  <= '0;
            hold_q     <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            road_q     <= road_d;
            rr_q       <= rr_d;
            ped_pend_q <= ped_pend_d;
            em_pend_q  <= em_pend_d;
            hold_q     <= hold_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign cmd_valid   = (state_q == OFFER);
    assign cmd_type    = cmd_valid ? type_q : CMD_NONE;
    assign cmd_road    = cmd_valid ? road_q : ROAD_N;
    assign ped_pending = ped_pend_q;
    assign em_pending  = em_pend_q;
    assign em_active   = (state_q == SERVE) && (type_q == CMD_EM);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_traffic_req_arbiter.sv
// Directed bench for traffic_req_arbiter with hand-computed cycle expectations
// (DEBOUNCE_CYC=4, PED_HOLDOFF=20, EM_TIMEOUT=60).
module tb_traffic_req_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] ped_req;
    logic [3:0] em_req;
    logic       fsm_ready;
    logic       fsm_done;
    logic       cmd_valid;
    logic [1:0] cmd_type;
    logic [1:0] cmd_road;
    logic [3:0] ped_pending;
    logic [3:0] em_pending;
    logic       em_active;
    logic       err_timeout;

    int n_cmp = 0;
    int n_err = 0;
    int gap;

    traffic_req_arbiter #(
        .DEBOUNCE_CYC(4), .PED_HOLDOFF(20), .EM_TIMEOUT(60)
    ) dut (
        .clk(clk), .reset(reset), .ped_req(ped_req), .em_req(em_req),
        .fsm_ready(fsm_ready), .fsm_done(fsm_done), .cmd_valid(cmd_valid),
        .cmd_type(cmd_type), .cmd_road(cmd_road), .ped_pending(ped_pending),
        .em_pending(em_pending), .em_active(em_active), .err_timeout(err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] all_out();
        return 32'({cmd_valid, cmd_type, cmd_road, ped_pending, em_pending,
                    em_active, err_timeout});
    endfunction

    task automatic pulse_done();
        fsm_done = 1'b1;
        tick();
        fsm_done = 1'b0;
    endtask

    // Called the cycle after a done pulse; gap counts cycles from that done.
    task automatic wait_offer(output int g);
        g = 1;
        while (!cmd_valid && g < 100) begin
            tick();
            g++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0; ped_req = '0; em_req = '0; fsm_ready = 1'b1; fsm_done = 1'b0;
        #2 reset = 1'b1;
        tick(2);
        check("reset_outputs", all_out(), 0);
        reset = 1'b0;

        // Single ped press on S.
        ped_req = 4'b0100;
        tick(3);
        check("ped_s_not_yet", 32'(ped_pending), 0);
        tick();
        check("ped_s_pending", 32'(ped_pending), 4'b0100);
        check("ped_s_no_valid_yet", 32'(cmd_valid), 0);
        ped_req = '0;
        tick();
        check("ped_s_offer", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd2});
        check("ped_s_pend_hs_cycle", 32'(ped_pending), 4'b0100);
        tick();
        check("ped_s_served", 32'({cmd_valid, ped_pending, em_active}), 0);
        pulse_done();

        // Three-cycle glitch never registers.
        ped_req = 4'b0001;
        tick(3);
        ped_req = '0;
        tick(5);
        check("glitch_no_pending", 32'(ped_pending), 0);
        check("glitch_no_valid", 32'(cmd_valid), 0);

        // Round-robin N, E, W with holdoff between services; rr starts at N.
        do_reset();
        ped_req = 4'b1011;
        tick(4);
        ped_req = '0;
        check("rr_all_pending", 32'(ped_pending), 4'b1011);
        tick();
        check("rr_first_n", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd0});
        tick();
        check("rr_after_n", 32'(ped_pending), 4'b1010);
        pulse_done();
        wait_offer(gap);
        // holdoff 20 at done+1, reaches 0 at done+21, offer at done+22
        check("rr_gap_e", 32'(gap), 22);
        check("rr_second_e", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd1});
        tick();
        check("rr_after_e", 32'(ped_pending), 4'b1000);
        pulse_done();
        wait_offer(gap);
        check("rr_gap_w", 32'(gap), 22);
        check("rr_third_w", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd3});
        tick();
        check("rr_after_w", 32'(ped_pending), 0);

        // Ped E offered without ready, then preempted by emergency W.
        fsm_ready = 1'b0;
        pulse_done();
        ped_req = 4'b0010;
        tick(4);
        ped_req = '0;
        wait_offer(gap);
        check("pre_ped_e_offer", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd1});
        em_req = 4'b1000;
        tick(3);
        check("pre_still_ped", 32'(cmd_type), 2'b01);
        tick();
        em_req = '0;
        check("pre_em_pending", 32'(em_pending), 4'b1000);
        check("pre_ped_this_cycle", 32'(cmd_type), 2'b01);
        tick();
        check("pre_em_offer", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b10, 2'd3});
        check("pre_ped_kept", 32'(ped_pending), 4'b0010);
        fsm_ready = 1'b1;
        tick();
        check("pre_em_active", 32'({cmd_valid, em_active, em_pending}), {1'b0, 1'b1, 4'b0000});
        check("pre_ped_still", 32'(ped_pending), 4'b0010);
        pulse_done();
        tick();
        check("pre_ped_resumes", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd1});
        tick();
        pulse_done();

        // Emergency N accepted but never completed.
        em_req = 4'b0001;
        tick(4);
        em_req = '0;
        check("tmo_em_pending", 32'(em_pending), 4'b0001);
        tick();
        check("tmo_offer", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b10, 2'd0});
        tick();
        check("tmo_serving", 32'({em_active, err_timeout}), 2'b10);
        tick(59);
        check("tmo_last_cycle", 32'({em_active, err_timeout}), 2'b10);
        tick();
        check("tmo_expired", 32'({cmd_valid, em_active, err_timeout}), 3'b001);
        tick(3);
        check("tmo_sticky", 32'(err_timeout), 1);

        // Reset in the middle of an emergency service with a ped waiting.
        em_req = 4'b0010;
        ped_req = 4'b0001;
        tick(4);
        em_req = '0;
        ped_req = '0;
        tick(2);
        check("rst_in_serve", 32'({em_active, ped_pending}), {1'b1, 4'b0001});
        reset = 1'b1;
        #1;
        check("rst_async_clear", all_out(), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ped_req = 4'b1010;
        tick(4);
        ped_req = '0;
        check("rst_new_pending", 32'(ped_pending), 4'b1010);
        tick();
        check("rst_new_offer", 32'({cmd_valid, cmd_type, cmd_road}), {1'b1, 2'b01, 2'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
